// File: rtl/amiga_clk_seq.sv
`default_nettype none
// ============================================================================
// Module   : amiga_clk_seq
// Purpose  : PLL-lock reset sequencer and 7 MHz / 3.5 MHz / E-clock phase
//            generator for a 28.375 MHz Amiga system clock.
//            Optional E-clock is built when AMIGA_CLK_SEQ_ECLK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module amiga_clk_seq #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  output logic rst_out_n,
  output logic clk7_en,
  output logic clk7n_en,
  output logic c1,
  output logic c3,
  output logic cck,
  output logic eclk,
  output logic eclk_en
);

  localparam logic [15:0] C_LOCK_LAST = 16'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_COUNT = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_lock_s;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [1:0]  r_ph;
  logic [1:0]  w_ph_next;
  logic        w_run_next;
  logic        w_clk7_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_ph    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ph    <= w_ph_next;
    end
  end

  // Loss of lock wins over counting and over the RUN phase sequence.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_HOLD: begin
        if (r_lock_s) begin
          w_state_next = S_COUNT;
          w_cnt_next   = '0;
        end
      end
      S_COUNT: begin
        if (!r_lock_s) begin
          w_state_next = S_HOLD;
        end else if (r_cnt == C_LOCK_LAST) begin
          w_state_next = S_RUN;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_next = S_HOLD;
        end
      end
      default: w_state_next = S_HOLD;
    endcase
  end

  assign w_run_next  = (w_state_next == S_RUN);
  assign w_ph_next   = (w_run_next && (r_state == S_RUN)) ? r_ph + 2'd1 : 2'd0;
  assign w_clk7_next = w_run_next && (w_ph_next == 2'd3);

  // Outputs are registered from next-state values so they line up with ph.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_out_n <= 1'b0;
      clk7_en   <= 1'b0;
      clk7n_en  <= 1'b0;
      c1        <= 1'b0;
      c3        <= 1'b0;
      cck       <= 1'b0;
    end else begin
      rst_out_n <= w_run_next;
      clk7_en   <= w_clk7_next;
      clk7n_en  <= w_run_next && (w_ph_next == 2'd1);
      c1        <= w_run_next && ((w_ph_next == 2'd0) || (w_ph_next == 2'd1));
      c3        <= w_run_next && ((w_ph_next == 2'd1) || (w_ph_next == 2'd2));
      cck       <= w_run_next ? (cck ^ w_clk7_next) : 1'b0;
    end
  end

`ifdef AMIGA_CLK_SEQ_ECLK_EN
  logic [3:0] r_ecnt;
  logic [3:0] w_ecnt_next;

  // E counter is mod 10 in 7 MHz ticks: 6 low, 4 high.
  always_comb begin
    w_ecnt_next = r_ecnt;
    if (!w_run_next) begin
      w_ecnt_next = 4'd0;
    end else if (w_clk7_next) begin
      w_ecnt_next = (r_ecnt == 4'd9) ? 4'd0 : r_ecnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ecnt  <= 4'd0;
      eclk    <= 1'b0;
      eclk_en <= 1'b0;
    end else begin
      r_ecnt  <= w_ecnt_next;
      eclk    <= (w_ecnt_next >= 4'd6);
      eclk_en <= w_run_next && w_clk7_next && (r_ecnt == 4'd9);
    end
  end
`else
  assign eclk    = 1'b0;
  assign eclk_en = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/amiga_clk_seq.md
AMIGA_CLK_SEQ -- requirements
Module: amiga_clk_seq

Interface
REQ-001 The parameter SHALL be LOCK_CYCLES, default 1024, the number of consecutive clk cycles of stable synchronized lock required before reset release (range 2..65535).
REQ-002 The port clk SHALL be an input, 1 bit: the 28.375 MHz system clock from the PLL 28 MHz output.
REQ-003 The port reset_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 The port pll_locked SHALL be an input, 1 bit: the PLL lock flag, asynchronous to clk.
REQ-005 The port rst_out_n SHALL be an output, 1 bit: sequenced system reset, active low.
REQ-006 The port clk7_en SHALL be an output, 1 bit: single-cycle 7 MHz enable.
REQ-007 The port clk7n_en SHALL be an output, 1 bit: single-cycle 7 MHz enable, 180 degrees from clk7_en.
REQ-008 The port c1 SHALL be an output, 1 bit: 7 MHz quadrature phase 1 level.
REQ-009 The port c3 SHALL be an output, 1 bit: 7 MHz quadrature phase 3 level.
REQ-010 The port cck SHALL be an output, 1 bit: 3.5 MHz colour clock level.
REQ-011 The port eclk SHALL be an output, 1 bit: 68000 E-clock level (ECLK_EN only).
REQ-012 The port eclk_en SHALL be an output, 1 bit: single-cycle pulse marking the E-clock falling edge (ECLK_EN only).

Function
REQ-013 The block SHALL pass pll_locked through a 2-flop synchronizer into lock_s before any use.
REQ-014 The block SHALL implement a three-state sequencer: HOLD, COUNT, RUN.
REQ-015 In HOLD: lock_s=1 -> COUNT with the lock counter cleared to 0.
REQ-016 In COUNT: the counter increments each cycle; counter == LOCK_CYCLES-1 -> RUN; lock_s=0 -> HOLD.
REQ-017 In RUN: lock_s=0 -> HOLD; this takes priority over all other activity in the same cycle.
REQ-018 rst_out_n SHALL be a registered output equal to 1 exactly while the state is RUN, so it rises one cycle after the COUNT->RUN transition.
REQ-019 The 2-bit phase counter ph SHALL be held at 0 outside RUN and increment mod 4 every clk cycle in RUN.
REQ-020 The enable and phase outputs SHALL be registered Moore outputs decoded from ph, all 0 outside RUN, with these decodes:
- clk7_en = 1 when ph==3
- clk7n_en = 1 when ph==1
- c1 = 1 when ph is 0 or 1
- c3 = 1 when ph is 1 or 2
REQ-021 The first clk7_en pulse SHALL occur on the 4th cycle after rst_out_n rises.
REQ-022 cck SHALL toggle in each cycle in which clk7_en is asserted and SHALL be held at 0 outside RUN.
REQ-023 Each full cck period SHALL span 8 clk cycles.
REQ-024 When lock is lost, all enables SHALL drop no later than the cycle in which rst_out_n falls, and no partial enable pulse SHALL be emitted afterwards.

Reset
REQ-025 When reset_n=0, the block SHALL asynchronously force:
- state to HOLD
- the synchronizer, lock counter, ph, and E counter to 0
- rst_out_n, clk7_en, clk7n_en, c1, c3, cck, eclk, and eclk_en to 0
REQ-026 On reset_n release, the block SHALL behave as in HOLD and require a full lock-count sequence before RUN.

Configuration
REQ-027 With the macro AMIGA_CLK_SEQ_ECLK_EN defined, the block SHALL run a mod-10 E counter advanced on each clk7_en in RUN, held at 0 outside RUN.
REQ-028 With AMIGA_CLK_SEQ_ECLK_EN defined, eclk SHALL be 1 for E counts 6..9 (6 low, 4 high 7 MHz cycles).
REQ-029 With AMIGA_CLK_SEQ_ECLK_EN defined, eclk_en SHALL pulse for one cycle on the clk7_en cycle in which the count wraps from 9 to 0.
REQ-030 Without AMIGA_CLK_SEQ_ECLK_EN, the eclk and eclk_en ports SHALL be present and tied to 0, and the E counter SHALL not be built.

Verification
REQ-031 Lock-up scenario (LOCK_CYCLES=16): pll_locked rises at cycle 0 -> lock_s=1 at cycle 2, rst_out_n=1 at cycle 19, first clk7_en at cycle 22.
REQ-032 Steady-run scenario (RUN held for 64 cycles): exactly 16 clk7_en pulses, 16 clk7n_en pulses each 2 cycles after a clk7_en, c1/c3 duty 50% offset by one cycle, and 8 full cck periods.
REQ-033 Lock-glitch-in-COUNT scenario: pll_locked dropped for 3 cycles at count 10 -> return to HOLD, rst_out_n stays 0, and a full 16-cycle recount follows re-lock.
REQ-034 Lock-loss-in-RUN scenario: pll_locked falls mid-run -> rst_out_n=0 and all enables 0 within 3 cycles, with ph, cck, and eclk at 0.
REQ-035 E-clock scenario (ECLK_EN defined): 100 clk7_en pulses -> eclk period of 40 clk cycles, high for 16, with 10 eclk_en pulses; without the macro, eclk and eclk_en remain 0.
REQ-036 Async-reset scenario: reset_n asserted mid-RUN between clock edges -> all outputs 0 immediately, without waiting for a clk edge.
